game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl_if.sv | 26 ++
 rtl/game_flow_ctrl.sv | 162 ++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: groups the controller's key, score and frame-gating signals.
//   master : controller side (drives Score_Reset, Frame_En, Level, Spawn_Period, Spawn, State)
//   slave  : environment side (drives Frame_Clk, Start, Pause, Score, gameOver)
interface game_flow_ctrl_if;
    logic        Frame_Clk;
    logic        Start;
    logic        Pause;
    logic [15:0] Score;
    logic        gameOver;
    logic        Score_Reset;
    logic        Frame_En;
    logic [2:0]  Level;
    logic [7:0]  Spawn_Period;
    logic        Spawn;
    logic [1:0]  State;

    modport master (
        input  Frame_Clk, Start, Pause, Score, gameOver,
        output Score_Reset, Frame_En, Level, Spawn_Period, Spawn, State
    );

    modport slave (
        output Frame_Clk, Start, Pause, Score, gameOver,
        input  Score_Reset, Frame_En, Level, Spawn_Period, Spawn, State
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer. Steps IDLE -> PLAYING <-> PAUSED -> OVER -> IDLE,
// gates the frame clock, raises difficulty level from the score and paces object spawns.
//   Clk          : system clock
//   Reset_n      : asynchronous active-low reset
//   gf (master)  : Frame_Clk/Start/Pause/Score/gameOver in;
//                  Score_Reset/Frame_En/Level/Spawn_Period/Spawn/State out
module game_flow_ctrl #(
    parameter int unsigned LEVEL_STEP  = 10,
    parameter int unsigned MAX_LEVEL   = 7,
    parameter int unsigned BASE_PERIOD = 60,
    parameter int unsigned PERIOD_STEP = 6,
    parameter int unsigned MIN_PERIOD  = 12,
    parameter int unsigned HOLD_FRAMES = 120
) (
    input logic             Clk,
    input logic             Reset_n,
    game_flow_ctrl_if.master gf
);

    localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPlaying = 2'd1,
        StPaused  = 2'd2,
        StOver    = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic             frame_prev_q, start_prev_q, pause_prev_q;
    logic             tick, start_edge, pause_edge;
    logic             frame_en_q, frame_en_d;
    logic [HoldW-1:0] hold_q;
    logic             hold_full;
    logic [2:0]       level_q;
    logic [15:0]      thr_q;
    logic [7:0]       spawn_cnt_q;
    logic [7:0]       period;
    logic             spawn_due;

    // Edge registers reset to 1 so a key held through reset is not taken as a press.
    assign tick       = gf.Frame_Clk & ~frame_prev_q;
    assign start_edge = gf.Start & ~start_prev_q;
    assign pause_edge = gf.Pause & ~pause_prev_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_prev_q <= 1'b1;
            start_prev_q <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            frame_prev_q <= gf.Frame_Clk;
            start_prev_q <= gf.Start;
            pause_prev_q <= gf.Pause;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start_edge) state_d = StPlaying;
            StPlaying: begin
                // gameOver wins over a simultaneous pause press.
                if (gf.gameOver)     state_d = StOver;
                else if (pause_edge) state_d = StPaused;
            end
            StPaused:  if (pause_edge) state_d = StPlaying;
            StOver:    if (start_edge && hold_full) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        gf.Score_Reset = (state_q == StIdle);
        gf.State       = state_q;
        gf.Spawn       = (state_q == StPlaying) & spawn_due;
    end

    // Frame_En only rises on a true tick, so entering PLAYING with Frame_Clk high is glitch-free.
    assign frame_en_d = gf.Frame_Clk & (state_q == StPlaying) & (frame_en_q | tick);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_en_q <= 1'b0;
        end else begin
            frame_en_q <= frame_en_d;
        end
    end

    assign gf.Frame_En = frame_en_q;

    // Hold counter: frame ticks spent in OVER, saturating; cleared in any other state.
    assign hold_full = (hold_q == HoldW'(HOLD_FRAMES));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_q <= '0;
        end else if (state_q != StOver) begin
            hold_q <= '0;
        end else if (tick && !hold_full) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    // Difficulty level: at most one step per Clk while the score is at or past the threshold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_q <= 3'd0;
            thr_q   <= 16'(LEVEL_STEP);
        end else if (state_q == StIdle) begin
            level_q <= 3'd0;
            thr_q   <= 16'(LEVEL_STEP);
        end else if (state_q == StPlaying && gf.Score >= thr_q && level_q < 3'(MAX_LEVEL)) begin
            level_q <= level_q + 3'd1;
            thr_q   <= thr_q + 16'(LEVEL_STEP);
        end
    end

    assign gf.Level = level_q;

    // Spawn period = max(BASE - level*STEP, MIN), with the subtraction guarded against wrap.
    always_comb begin
        int unsigned dec;
        int unsigned diff;
        dec  = {29'd0, level_q} * PERIOD_STEP;
        diff = 0;
        if (dec >= BASE_PERIOD) begin
            period = 8'(MIN_PERIOD);
        end else begin
            diff   = BASE_PERIOD - dec;
            period = (diff < MIN_PERIOD) ? 8'(MIN_PERIOD) : 8'(diff);
        end
    end

    assign gf.Spawn_Period = period;

    // Spawn counter: level changes only take effect at the next reload.
    assign spawn_due = tick & (spawn_cnt_q <= 8'd1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            spawn_cnt_q <= 8'(BASE_PERIOD);
        end else if (state_q == StIdle && start_edge) begin
            spawn_cnt_q <= period;
        end else if (state_q == StPlaying && tick) begin
            spawn_cnt_q <= spawn_due ? period : spawn_cnt_q - 8'd1;
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
module tb_game_flow_ctrl;

    logic Clk;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    game_flow_ctrl_if gf ();
    game_flow_ctrl_if gf2 ();

    // Second instance with a steep PERIOD_STEP shares all stimulus.
    assign gf2.Frame_Clk = gf.Frame_Clk;
    assign gf2.Start     = gf.Start;
    assign gf2.Pause     = gf.Pause;
    assign gf2.Score     = gf.Score;
    assign gf2.gameOver  = gf.gameOver;

    game_flow_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .gf      (gf.master)
    );

    game_flow_ctrl #(.PERIOD_STEP(10)) dut2 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .gf      (gf2.master)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One frame tick: Frame_Clk high for one Clk, then low for one Clk.
    task automatic frame_tick(output logic spawned, output logic fe);
        @(posedge Clk); #1 gf.Frame_Clk = 1'b1;
        @(negedge Clk); spawned = gf.Spawn;
        @(posedge Clk); #1 fe = gf.Frame_En; gf.Frame_Clk = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic run_ticks(input int n, output int spawns, output int first_at,
                             output int last_at, output int fe_hits);
        logic s, f;
        spawns = 0; first_at = 0; last_at = 0; fe_hits = 0;
        for (int i = 1; i <= n; i++) begin
            frame_tick(s, f);
            if (s) begin
                spawns++;
                if (first_at == 0) first_at = i;
                last_at = i;
            end
            if (f) fe_hits++;
        end
    endtask

    task automatic start_pulse();
        @(posedge Clk); #1 gf.Start = 1'b1;
        @(posedge Clk); #1 gf.Start = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        int sp, fa, la, fh;

        Reset_n      = 1'b0;
        gf.Frame_Clk = 1'b0;
        gf.Start     = 1'b0;
        gf.Pause     = 1'b0;
        gf.Score     = 16'd0;
        gf.gameOver  = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_state",  32'(gf.State), 0);
        check("rst_sreset", 32'(gf.Score_Reset), 1);
        check("rst_fe",     32'(gf.Frame_En), 0);
        check("rst_level",  32'(gf.Level), 0);
        check("rst_period", 32'(gf.Spawn_Period), 60);
        check("rst_spawn",  32'(gf.Spawn), 0);
        Reset_n = 1'b1;
        repeat (2) @(posedge Clk);
        #1 check("idle_stays", 32'(gf.State), 0);

        // Start edge: state changes one Clk later.
        @(posedge Clk); #1 gf.Start = 1'b1;
        @(negedge Clk);
        check("start_pre", 32'(gf.State), 0);
        @(posedge Clk); #1
        check("start_play",   32'(gf.State), 1);
        check("start_sreset", 32'(gf.Score_Reset), 0);
        check("start_fe_low", 32'(gf.Frame_En), 0);
        gf.Start = 1'b0;

        // 120 ticks at level 0: spawns on ticks 60 and 120; Frame_En follows every tick.
        run_ticks(120, sp, fa, la, fh);
        check("l0_spawns", 32'(sp), 2);
        check("l0_first",  32'(fa), 60);
        check("l0_second", 32'(la), 120);
        check("l0_fe",     32'(fh), 120);

        // Counter at 60; consume 7 -> 53 remaining, then pause.
        run_ticks(7, sp, fa, la, fh);
        check("pre_pause_spawns", 32'(sp), 0);
        @(posedge Clk); #1 gf.Pause = 1'b1;
        @(posedge Clk); #1 gf.Pause = 1'b0;
        check("paused", 32'(gf.State), 2);
        run_ticks(50, sp, fa, la, fh);
        check("pause_spawns", 32'(sp), 0);
        check("pause_fe",     32'(fh), 0);
        check("pause_stays",  32'(gf.State), 2);
        @(posedge Clk); #1 gf.Pause = 1'b1;
        @(posedge Clk); #1 gf.Pause = 1'b0;
        check("resumed", 32'(gf.State), 1);
        run_ticks(52, sp, fa, la, fh);
        check("resume_52_spawns", 32'(sp), 0);
        run_ticks(1, sp, fa, la, fh);
        check("resume_53_spawn", 32'(sp), 1);

        // Level stepping.
        @(posedge Clk); #1 gf.Score = 16'd25;
        @(negedge Clk);
        check("lvl_pre", 32'(gf.Level), 0);
        @(posedge Clk); #1
        check("lvl1",     32'(gf.Level), 1);
        check("lvl1_per", 32'(gf.Spawn_Period), 54);
        @(posedge Clk); #1
        check("lvl2",      32'(gf.Level), 2);
        check("lvl2_per",  32'(gf.Spawn_Period), 48);
        check("lvl2_per10", 32'(gf2.Spawn_Period), 40);
        @(posedge Clk); #1
        check("lvl2_hold", 32'(gf.Level), 2);
        gf.Score = 16'd200;
        repeat (8) @(posedge Clk);
        #1
        check("lvl7",        32'(gf.Level), 7);
        check("lvl7_per",    32'(gf.Spawn_Period), 18);
        check("lvl7_b",      32'(gf2.Level), 7);
        check("lvl7_per10",  32'(gf2.Spawn_Period), 12);

        // In-flight count (60 loaded at level 0) finishes before the new period applies.
        run_ticks(59, sp, fa, la, fh);
        check("inflight_59", 32'(sp), 0);
        run_ticks(1, sp, fa, la, fh);
        check("inflight_60", 32'(sp), 1);
        run_ticks(18, sp, fa, la, fh);
        check("fast_spawns", 32'(sp), 1);
        check("fast_at",     32'(fa), 18);

        // gameOver beats simultaneous Pause.
        @(posedge Clk); #1 gf.gameOver = 1'b1; gf.Pause = 1'b1;
        @(posedge Clk); #1
        check("over",        32'(gf.State), 3);
        check("over_sreset", 32'(gf.Score_Reset), 0);
        check("over_b",      32'(gf2.State), 3);
        gf.gameOver = 1'b0; gf.Pause = 1'b0;
        run_ticks(100, sp, fa, la, fh);
        check("over_spawns", 32'(sp), 0);
        check("over_fe",     32'(fh), 0);
        start_pulse();
        check("start_at_100", 32'(gf.State), 3);
        run_ticks(19, sp, fa, la, fh);
        start_pulse();
        check("start_at_119", 32'(gf.State), 3);
        run_ticks(1, sp, fa, la, fh);
        start_pulse();
        check("start_at_120", 32'(gf.State), 0);
        check("idle_sreset",  32'(gf.Score_Reset), 1);
        check("idle_level",   32'(gf.Level), 0);
        check("idle_period",  32'(gf.Spawn_Period), 60);

        // Asynchronous reset mid-game while Frame_En is high.
        start_pulse();
        check("replay", 32'(gf.State), 1);
        repeat (10) @(posedge Clk);
        #1 check("replay_lvl7", 32'(gf.Level), 7);
        @(posedge Clk); #1 gf.Frame_Clk = 1'b1;
        @(posedge Clk); #1
        check("replay_fe", 32'(gf.Frame_En), 1);
        #2 Reset_n = 1'b0;
        #1
        check("arst_state",  32'(gf.State), 0);
        check("arst_sreset", 32'(gf.Score_Reset), 1);
        check("arst_fe",     32'(gf.Frame_En), 0);
        check("arst_level",  32'(gf.Level), 0);
        check("arst_period", 32'(gf.Spawn_Period), 60);
        check("arst_spawn",  32'(gf.Spawn), 0);
        gf.Frame_Clk = 1'b0;
        @(negedge Clk); Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1 check("post_rst_idle", 32'(gf.State), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
